// File: rtl/ps2_arrow_decoder.sv
// PS/2 scan-code parser: turns E0/F0-prefixed arrow codes into held levels,
// fresh-make pulses, the most recent direction and a protocol-error pulse.
module ps2_arrow_decoder #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] ps2_key_data,
  input  logic       ps2_key_pressed,
  output logic       left,
  output logic       right,
  output logic       up,
  output logic       down,
  output logic       left_p,
  output logic       right_p,
  output logic       up_p,
  output logic       down_p,
  output logic [1:0] last_dir,
  output logic       proto_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Index 0..3 = left, right, up, down; matches the last_dir encoding.
  logic [3:0]    lvl_q, lvl_d;
  logic [3:0]    pls_q, pls_d;
  logic [1:0]    dir_q, dir_d;
  logic          err_q, err_d;

  logic       is_arrow, is_err;
  logic [1:0] idx;

  always_comb begin
    is_arrow = 1'b1;
    idx      = 2'd0;
    case (ps2_key_data)
      8'h6B:   idx = 2'd0;
      8'h74:   idx = 2'd1;
      8'h75:   idx = 2'd2;
      8'h72:   idx = 2'd3;
      default: is_arrow = 1'b0;
    endcase
    is_err = (ps2_key_data == 8'hAA) || (ps2_key_data == 8'hFC) ||
             (ps2_key_data == 8'h00) || (ps2_key_data == 8'hFF);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lvl_q   <= '0;
      pls_q   <= '0;
      dir_q   <= 2'b00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      pls_q   <= pls_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    lvl_d   = lvl_q;
    pls_d   = '0;
    dir_d   = dir_q;
    err_d   = 1'b0;
    if (ps2_key_pressed || state_q == S_IDLE) cnt_d = '0;

    if (ps2_key_pressed) begin
      if (is_err) begin
        lvl_d   = '0;
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (ps2_key_data == 8'hE0)      state_d = S_E0;
            else if (ps2_key_data == 8'hF0) state_d = S_F0;
          end
          S_E0: begin
            if (ps2_key_data == 8'hF0)      state_d = S_E0F0;
            else if (ps2_key_data == 8'hE0) state_d = S_E0;
            else begin
              state_d = S_IDLE;
              if (is_arrow) begin
                // Typematic repeats keep the level but must not re-pulse.
                if (!lvl_q[idx]) begin
                  pls_d[idx] = 1'b1;
                  dir_d      = idx;
                end
                lvl_d[idx] = 1'b1;
              end
            end
          end
          S_E0F0: begin
            if (is_arrow) begin
              lvl_d[idx] = 1'b0;
              state_d    = S_IDLE;
            end else if (ps2_key_data == 8'hE0) begin
              state_d = S_E0;
            end else begin
              state_d = S_IDLE;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end else if (state_q != S_IDLE && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end
  end

  assign left      = lvl_q[0];
  assign right     = lvl_q[1];
  assign up        = lvl_q[2];
  assign down      = lvl_q[3];
  assign left_p    = pls_q[0];
  assign right_p   = pls_q[1];
  assign up_p      = pls_q[2];
  assign down_p    = pls_q[3];
  assign last_dir  = dir_q;
  assign proto_err = err_q;
endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// Table-driven bench for ps2_arrow_decoder; expected outputs queued at drive
// time and popped after the clock edge that should produce them.
module tb_ps2_arrow_decoder;
  localparam int TO = 16;

  logic       clock = 1'b0;
  logic       resetn;
  logic [7:0] ps2_key_data;
  logic       ps2_key_pressed;
  logic       left, right, up, down, left_p, right_p, up_p, down_p, proto_err;
  logic [1:0] last_dir;

  ps2_arrow_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .resetn(resetn),
    .ps2_key_data(ps2_key_data), .ps2_key_pressed(ps2_key_pressed),
    .left(left), .right(right), .up(up), .down(down),
    .left_p(left_p), .right_p(right_p), .up_p(up_p), .down_p(down_p),
    .last_dir(last_dir), .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  // Expected packing: {left,right,up,down, left_p,right_p,up_p,down_p, last_dir, proto_err}
  typedef struct {
    logic       stb;
    logic [7:0] b;
    logic [3:0] lv;
    logic [3:0] pl;
    logic [1:0] ld;
    logic       err;
  } vec_t;

  vec_t        tbl[$];
  logic [10:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;

  function automatic void add(input logic stb, input logic [7:0] b, input logic [3:0] lv,
                              input logic [3:0] pl, input logic [1:0] ld, input logic err);
    vec_t v;
    v.stb = stb; v.b = b; v.lv = lv; v.pl = pl; v.ld = ld; v.err = err;
    tbl.push_back(v);
  endfunction

  task automatic step(input string name, input logic rstn, input logic stb, input logic [7:0] b,
                      input logic [3:0] lv, input logic [3:0] pl, input logic [1:0] ld,
                      input logic err);
    logic [10:0] got, exp;
    @(negedge clock);
    resetn          = rstn;
    ps2_key_pressed = stb;
    ps2_key_data    = b;
    exp_q.push_back({lv, pl, ld, err});
    @(posedge clock);
    #1;
    got = {left, right, up, down, left_p, right_p, up_p, down_p, last_dir, proto_err};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%b expected=%b", name, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; ps2_key_pressed = 1'b0; ps2_key_data = 8'h00;
    // Levels/pulses nibble order: left,right,up,down.
    // up make then break
    add(1, 8'hE0, 4'b0000, 4'b0000, 2'd0, 0);
    add(1, 8'h75, 4'b0010, 4'b0010, 2'd2, 0);
    add(0, 8'h00, 4'b0010, 4'b0000, 2'd2, 0);
    add(1, 8'hE0, 4'b0010, 4'b0000, 2'd2, 0);
    add(1, 8'hF0, 4'b0010, 4'b0000, 2'd2, 0);
    add(1, 8'h75, 4'b0000, 4'b0000, 2'd2, 0);
    // right held with typematic repeats
    add(1, 8'hE0, 4'b0000, 4'b0000, 2'd2, 0);
    add(1, 8'h74, 4'b0100, 4'b0100, 2'd1, 0);
    add(1, 8'hE0, 4'b0100, 4'b0000, 2'd1, 0);
    add(1, 8'h74, 4'b0100, 4'b0000, 2'd1, 0);
    add(1, 8'hE0, 4'b0100, 4'b0000, 2'd1, 0);
    add(1, 8'h74, 4'b0100, 4'b0000, 2'd1, 0);
    // left + down simultaneously, then BAT byte
    add(1, 8'hE0, 4'b0100, 4'b0000, 2'd1, 0);
    add(1, 8'h6B, 4'b1100, 4'b1000, 2'd0, 0);
    add(1, 8'hE0, 4'b1100, 4'b0000, 2'd0, 0);
    add(1, 8'h72, 4'b1101, 4'b0001, 2'd3, 0);
    add(1, 8'hAA, 4'b0000, 4'b0000, 2'd3, 1);
    add(0, 8'h00, 4'b0000, 4'b0000, 2'd3, 0);
    // non-extended codes, E0 12, double E0
    add(1, 8'h6B, 4'b0000, 4'b0000, 2'd3, 0);
    add(1, 8'hF0, 4'b0000, 4'b0000, 2'd3, 0);
    add(1, 8'h6B, 4'b0000, 4'b0000, 2'd3, 0);
    add(1, 8'hE0, 4'b0000, 4'b0000, 2'd3, 0);
    add(1, 8'h12, 4'b0000, 4'b0000, 2'd3, 0);
    add(1, 8'hE0, 4'b0000, 4'b0000, 2'd3, 0);
    add(1, 8'hE0, 4'b0000, 4'b0000, 2'd3, 0);
    add(1, 8'h72, 4'b0001, 4'b0001, 2'd3, 0);
    // error byte mid-prefix has priority
    add(1, 8'hE0, 4'b0001, 4'b0000, 2'd3, 0);
    add(1, 8'hFF, 4'b0000, 4'b0000, 2'd3, 1);
    // break of a key that is not held
    add(1, 8'hE0, 4'b0000, 4'b0000, 2'd3, 0);
    add(1, 8'hF0, 4'b0000, 4'b0000, 2'd3, 0);
    add(1, 8'h6B, 4'b0000, 4'b0000, 2'd3, 0);

    step("reset", 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 2'd0, 0);
    foreach (tbl[i])
      step($sformatf("vec%0d", i), 1'b1, tbl[i].stb, tbl[i].b, tbl[i].lv, tbl[i].pl, tbl[i].ld, tbl[i].err);

    // Prefix timeout: fires on the 16th idle cycle only.
    step("to_e0", 1'b1, 1'b1, 8'hE0, 4'b0000, 4'b0000, 2'd3, 0);
    for (int k = 1; k < TO; k++)
      step($sformatf("to_wait%0d", k), 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 2'd3, 0);
    step("to_fire", 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 2'd3, 1);
    step("to_after", 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 2'd3, 0);
    step("to_75", 1'b1, 1'b1, 8'h75, 4'b0000, 4'b0000, 2'd3, 0);

    // Strobe in the timeout cycle wins.
    step("tw_e0", 1'b1, 1'b1, 8'hE0, 4'b0000, 4'b0000, 2'd3, 0);
    for (int k = 1; k < TO; k++)
      step($sformatf("tw_wait%0d", k), 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 2'd3, 0);
    step("tw_75", 1'b1, 1'b1, 8'h75, 4'b0010, 4'b0010, 2'd2, 0);

    // Reset mid-sequence discards the prefix.
    step("rs_e0", 1'b1, 1'b1, 8'hE0, 4'b0010, 4'b0000, 2'd2, 0);
    step("rs_f0", 1'b1, 1'b1, 8'hF0, 4'b0010, 4'b0000, 2'd2, 0);
    step("rs_rst", 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 2'd0, 0);
    step("rs_74", 1'b1, 1'b1, 8'h74, 4'b0000, 4'b0000, 2'd0, 0);
    step("rs_idle", 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 2'd0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
